ascon_sbox_layer: RTL and testbench
===================================

Name: ascon_sbox_layer

Overview:
- Ascon permutation substitution layer (p_S).
- Applies the 5-bit Ascon S-box in bit-sliced form to all columns of the 320-bit state (5 lanes x 64 bits).
- Sits between the constant-addition stage and the linear-diffusion stage of the permutation round.
- This version registers the result: one-cycle latency with a valid strobe.

Parameters:
- LANE_W, 64, width of each state lane and number of S-box columns. Only 64 is required for Ascon; RTL must stay generic in it.

Ports:
- clock_i  input  1  rising-edge clock
- resetb_i  input  1  asynchronous active-low reset
- ps_i  input  5xLANE_W (type_state from ascon_pack, lanes [0..4])  state entering the substitution layer
- valid_i  input  1  ps_i is valid this cycle
- ps_o  output  5xLANE_W (type_state)  substituted state, registered
- valid_o  output  1  ps_o holds a fresh result

Behaviour:
- Column j (0..LANE_W-1): x = {ps_i[0][j], ps_i[1][j], ps_i[2][j], ps_i[3][j], ps_i[4][j]}, with lane 0 as the MSB.
- Output column: y = SBOX[x]; ps_o[k][j] = y[4-k].
- SBOX, indices 0..31 in hex: 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17.
- Implementation may use a LUT or the Ascon boolean equations; the result must be bit-exact to the table.
- Reset (resetb_i low, asynchronous): ps_o = all zeros, valid_o = 0. Both are held while reset is low.
- Reset release: outputs change only on rising edges of clock_i.
- On a rising edge with valid_i=1: ps_o <= SBOX(ps_i) and valid_o <= 1. Latency is exactly 1 cycle.
- On a rising edge with valid_i=0: ps_o holds its previous value and valid_o <= 0.
- Back-to-back valid_i: a new result every cycle. There is no backpressure and no stall.
- Reset asserted mid-stream: any in-flight result is discarded and outputs go to reset values immediately.
- No internal state other than the output registers. The block is stateless between transactions.

Optional Feature:
- Macro ASCON_SBOX_BYPASS_EN.
- When defined:
  - Adds input port bypass_i (1 bit).
  - A rising edge with valid_i=1 and bypass_i=1 registers ps_i unchanged into ps_o; valid_o behaves as normal.
  - bypass_i is ignored when valid_i=0.
- When not defined:
  - The port does not exist.
  - Every valid transaction is substituted.

Test Plan:
- Reset: hold resetb_i=0 with random ps_i and valid_i=1 -> ps_o=0, valid_o=0 throughout. Release, apply one valid cycle -> valid_o=1 exactly one cycle later.
- All-zero input, valid_i=1 -> next cycle lanes 0,1,3,4 = 0x0000000000000000 and lane 2 = 0xFFFFFFFFFFFFFFFF.
- All-ones input -> next cycle lanes 0,2,3,4 = 0xFFFFFFFFFFFFFFFF and lane 1 = 0x0000000000000000.
- Single bit, lane0 = 0x0000000000000001, others 0 -> lane0 = 0x0000000000000001, lane1 = 0x0000000000000001, lane2 = 0xFFFFFFFFFFFFFFFF, lane3 = 0x0000000000000001, lane4 = 0x0000000000000000.
- Round vector:
  - Stimulus: lanes = 80400c0600000000, 0001020304050607, 08090a0b0c0d0eff, 0011223344556677, 8899aabbccddeeff.
  - Stream it back-to-back with two random states, then drop valid_i.
  - Required: each output matches the golden table model one cycle later; after valid_i drops, ps_o holds and valid_o=0.
- With ASCON_SBOX_BYPASS_EN defined: bypass_i=1 on the round vector -> ps_o equals the input lanes unchanged one cycle later. Then assert resetb_i low mid-stream -> outputs clear immediately.

Source files
------------

// File: rtl/ascon_sbox_layer_if.sv
// +----------------------------------------------------------------------------+
// | ascon_sbox_layer_if : state/valid bus into and out of the Ascon p_S layer  |
// | Optional bypass_i exists only when ASCON_SBOX_BYPASS_EN is defined.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ascon_sbox_layer_if #(
  parameter int LANE_W = 64
);
  logic [4:0][LANE_W-1:0] ps_i;
  logic                   valid_i;
`ifdef ASCON_SBOX_BYPASS_EN
  logic                   bypass_i;
`endif
  logic [4:0][LANE_W-1:0] ps_o;
  logic                   valid_o;

  modport master (
    output ps_i,
    output valid_i,
`ifdef ASCON_SBOX_BYPASS_EN
    output bypass_i,
`endif
    input  ps_o,
    input  valid_o
  );

  modport slave (
    input  ps_i,
    input  valid_i,
`ifdef ASCON_SBOX_BYPASS_EN
    input  bypass_i,
`endif
    output ps_o,
    output valid_o
  );
endinterface

`default_nettype wire

// File: rtl/ascon_sbox_layer.sv
// +----------------------------------------------------------------------------+
// | ascon_sbox_layer : Ascon p_S, 5-bit S-box on every column, registered out. |
// | Optional macro ASCON_SBOX_BYPASS_EN adds a pass-through control.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ascon_sbox_layer #(
  parameter int LANE_W = 64
) (
  input  wire logic         clock_i,
  input  wire logic         resetb_i,
  ascon_sbox_layer_if.slave bus
);

  function automatic logic [4:0] sbox5(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'd0:  y = 5'h04;  5'd1:  y = 5'h0b;  5'd2:  y = 5'h1f;  5'd3:  y = 5'h14;
      5'd4:  y = 5'h1a;  5'd5:  y = 5'h15;  5'd6:  y = 5'h09;  5'd7:  y = 5'h02;
      5'd8:  y = 5'h1b;  5'd9:  y = 5'h05;  5'd10: y = 5'h08;  5'd11: y = 5'h12;
      5'd12: y = 5'h1d;  5'd13: y = 5'h03;  5'd14: y = 5'h06;  5'd15: y = 5'h1c;
      5'd16: y = 5'h1e;  5'd17: y = 5'h13;  5'd18: y = 5'h07;  5'd19: y = 5'h0e;
      5'd20: y = 5'h00;  5'd21: y = 5'h0d;  5'd22: y = 5'h11;  5'd23: y = 5'h18;
      5'd24: y = 5'h10;  5'd25: y = 5'h0c;  5'd26: y = 5'h01;  5'd27: y = 5'h19;
      5'd28: y = 5'h16;  5'd29: y = 5'h0a;  5'd30: y = 5'h0f;  default: y = 5'h17;
    endcase
    return y;
  endfunction

  logic [4:0][LANE_W-1:0] w_ps_sub;
  logic [4:0][LANE_W-1:0] w_ps_next;
  logic [4:0][LANE_W-1:0] r_ps;
  logic                   r_valid;

  // Column j gathers bit j of every lane, lane 0 as the MSB of the S-box index.
  for (genvar j = 0; j < LANE_W; j++) begin : g_col
    logic [4:0] w_x;
    logic [4:0] w_y;
    assign w_x = {bus.ps_i[0][j], bus.ps_i[1][j], bus.ps_i[2][j],
                  bus.ps_i[3][j], bus.ps_i[4][j]};
    assign w_y = sbox5(w_x);
    for (genvar k = 0; k < 5; k++) begin : g_lane
      assign w_ps_sub[k][j] = w_y[4-k];
    end
  end

`ifdef ASCON_SBOX_BYPASS_EN
  assign w_ps_next = bus.bypass_i ? bus.ps_i : w_ps_sub;
`else
  assign w_ps_next = w_ps_sub;
`endif

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_ps    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.valid_i;
      if (bus.valid_i) begin
        r_ps <= w_ps_next;
      end
    end
  end

  assign bus.ps_o    = r_ps;
  assign bus.valid_o = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_ascon_sbox_layer.sv
// Directed + random stimulus for ascon_sbox_layer against a table-driven column model.
`default_nettype none

module tb_ascon_sbox_layer;

  typedef logic [4:0][63:0] state_t;

  logic clock_i  = 1'b0;
  logic resetb_i = 1'b0;

  ascon_sbox_layer_if #(.LANE_W(64)) bus ();

  ascon_sbox_layer #(.LANE_W(64)) dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .bus      (bus)
  );

  always #5 clock_i = ~clock_i;

  logic [4:0] tbl [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                           5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                           5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                           5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  int     errors = 0;
  int     checks = 0;
  state_t exp_ps;
  logic   exp_valid;

  function automatic state_t ref_sbox(input state_t s);
    state_t r;
    int     x;
    int     y;
    r = '0;
    for (int j = 0; j < 64; j++) begin
      x = 0;
      for (int k = 0; k < 5; k++) x = x * 2 + int'(s[k][j]);
      y = int'(tbl[x]);
      for (int k = 0; k < 5; k++) r[k][j] = y[4-k];
    end
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic check_state(input string tag, input state_t obs, input state_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied 1 time unit after an edge, outputs checked 1 unit after the next.
  task automatic step(input string tag, input state_t ps, input logic vld, input logic byp);
    bus.ps_i    = ps;
    bus.valid_i = vld;
`ifdef ASCON_SBOX_BYPASS_EN
    bus.bypass_i = byp;
`endif
    @(posedge clock_i);
    #1;
    if (vld) begin
`ifdef ASCON_SBOX_BYPASS_EN
      exp_ps = byp ? ps : ref_sbox(ps);
`else
      exp_ps = ref_sbox(ps);
`endif
    end
    exp_valid = vld;
    check_state({tag, "_ps"}, bus.ps_o, exp_ps);
    check_bit({tag, "_valid"}, bus.valid_o, exp_valid);
  endtask

  initial begin
    state_t s;
    state_t rv;
    logic   unused_byp;
    bus.ps_i    = rand_state();
    bus.valid_i = 1'b1;
`ifdef ASCON_SBOX_BYPASS_EN
    bus.bypass_i = 1'b0;
`endif
    unused_byp = 1'b0;

    // Held in reset with live valid input
    for (int i = 0; i < 3; i++) begin
      bus.ps_i = rand_state();
      @(posedge clock_i);
      #1;
      check_state("reset_ps", bus.ps_o, '0);
      check_bit("reset_valid", bus.valid_o, 1'b0);
    end
    resetb_i = 1'b1;
    exp_ps = '0;

    // All zeros
    step("zero", '0, 1'b1, unused_byp);
    check_state("zero_const", bus.ps_o,
                {64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0});
    // All ones
    step("ones", '1, 1'b1, unused_byp);
    check_state("ones_const", bus.ps_o,
                {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                 64'h0, 64'hFFFFFFFFFFFFFFFF});
    // Single bit in lane 0 (lane 4 is the MSB slice of the packed literal)
    s = '0;
    s[0] = 64'h1;
    step("bit", s, 1'b1, unused_byp);
    check_state("bit_const", bus.ps_o,
                {64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h1});

    // Round vector streamed with two random states, then valid drops
    rv[0] = 64'h80400c0600000000;
    rv[1] = 64'h0001020304050607;
    rv[2] = 64'h08090a0b0c0d0eff;
    rv[3] = 64'h0011223344556677;
    rv[4] = 64'h8899aabbccddeeff;
    step("round", rv, 1'b1, 1'b0);
    step("rand_a", rand_state(), 1'b1, 1'b0);
    step("rand_b", rand_state(), 1'b1, 1'b0);
    step("idle_a", rand_state(), 1'b0, 1'b0);
    step("idle_b", rand_state(), 1'b0, 1'b0);

    // Random traffic with random gaps
    for (int i = 0; i < 24; i++) begin
      step("rand", rand_state(), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef ASCON_SBOX_BYPASS_EN
    step("byp_round", rv, 1'b1, 1'b1);
    check_state("byp_equal", bus.ps_o, rv);
    step("byp_idle", rand_state(), 1'b0, 1'b1);
    step("byp_off", rv, 1'b1, 1'b0);
`endif

    // Reset mid-stream: outputs clear without waiting for an edge
    step("pre_rst", rand_state(), 1'b1, 1'b1);
    bus.ps_i    = rand_state();
    bus.valid_i = 1'b1;
    #2;
    resetb_i = 1'b0;
    #1;
    check_state("async_rst_ps", bus.ps_o, '0);
    check_bit("async_rst_valid", bus.valid_o, 1'b0);
    @(posedge clock_i);
    #1;
    check_state("rst_hold_ps", bus.ps_o, '0);
    check_bit("rst_hold_valid", bus.valid_o, 1'b0);
    resetb_i = 1'b1;
    exp_ps = '0;
    step("post_rst", rand_state(), 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
